// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared ALU opcode encoding, flag bit positions and the
//             stage-1 operand record used by the issue stage.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

    // Bit positions inside the 4-bit {N,Z,C,O} flag vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_O = 0;

    // Operation as captured by the operand register
    typedef struct packed {
        alu_op_e    op;
        logic [7:0] a;
        logic [7:0] b;
        logic       use_acc;
        logic       wr_acc;
    } s1_entry_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/tiny_alu.sv
`default_nettype none
// ============================================================================
//  Module   : tiny_alu
//  Purpose  : 8-bit combinational ALU (ADD/SUB/AND/OR) producing {N,Z,C,O}.
//             SUB is computed as A + ~B + 1, so C=1 means "no borrow".
//             C and O are forced to 0 for the logic operations.
//  Revision : 1.0 - initial release
// ============================================================================
module tiny_alu
    import alu_pkg::*;
(
    input  alu_op_e    op_i,
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] res_o,
    output logic [3:0] flags_o
);

    logic [8:0] w_sum;
    logic [7:0] w_res;
    logic       w_carry;
    logic       w_ovf;

    // Result, carry and signed overflow for the selected operation
    always_comb begin
        w_sum   = 9'h000;
        w_res   = 8'h00;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (op_i)
            ALU_ADD: begin
                w_sum   = {1'b0, a_i} + {1'b0, b_i};
                w_res   = w_sum[7:0];
                w_carry = w_sum[8];
                w_ovf   = (a_i[7] == b_i[7]) && (w_res[7] != a_i[7]);
            end
            ALU_SUB: begin
                w_sum   = {1'b0, a_i} + {1'b0, ~b_i} + 9'd1;
                w_res   = w_sum[7:0];
                w_carry = w_sum[8];
                w_ovf   = (a_i[7] != b_i[7]) && (w_res[7] != a_i[7]);
            end
            ALU_AND: w_res = a_i & b_i;
            ALU_OR:  w_res = a_i | b_i;
            default: w_res = 8'h00;
        endcase
    end

    // Pack result and flag vector
    always_comb begin
        res_o           = w_res;
        flags_o         = 4'h0;
        flags_o[FLAG_N] = w_res[7];
        flags_o[FLAG_Z] = (w_res == 8'h00);
        flags_o[FLAG_C] = w_carry;
        flags_o[FLAG_O] = w_ovf;
    end

endmodule : tiny_alu
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_stage
//  Purpose  : Two-stage issue/writeback wrapper around tiny_alu with an 8-bit
//             accumulator. Stage 1 holds operands, the ALU sits between the
//             stages, stage 2 holds result/flags for the downstream consumer.
//             The accumulator is written at the same edge an op leaves stage
//             1, so a following op already in stage 1 reads the new value.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter logic [7:0] ACC_INIT = 8'h00
)(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic [1:0] op_i,
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       use_acc_i,
    input  logic       wr_acc_i,
    input  logic       acc_clr_i,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic [7:0] res_o,
    output logic [3:0] flags_o,
    output logic [7:0] acc_o
);

    s1_entry_t  s1_q,       s1_d;
    logic       s1_valid_q, s1_valid_d;
    logic       s2_valid_q, s2_valid_d;
    logic [7:0] res_q,      res_d;
    logic [3:0] flags_q,    flags_d;
    logic [7:0] acc_q,      acc_d;

    logic       w_s1_adv;
    logic       w_accept;
    logic [7:0] w_alu_a;
    logic [7:0] w_alu_res;
    logic [3:0] w_alu_flags;

    // Handshake: stage 1 empties whenever stage 2 is free or being drained
    always_comb begin
        w_s1_adv   = s1_valid_q && (!s2_valid_q || out_ready_i);
        in_ready_o = !s1_valid_q || w_s1_adv;
        w_accept   = in_valid_i && in_ready_o;
        w_alu_a    = s1_q.use_acc ? acc_q : s1_q.a;
    end

    tiny_alu u_alu (
        .op_i    (s1_q.op),
        .a_i     (w_alu_a),
        .b_i     (b_i_unused_guard(s1_q.b)),
        .res_o   (w_alu_res),
        .flags_o (w_alu_flags)
    );

    function automatic logic [7:0] b_i_unused_guard(input logic [7:0] v);
        return v;
    endfunction

    // Next-state for both pipeline stages and the accumulator
    always_comb begin
        s1_d       = s1_q;
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        res_d      = res_q;
        flags_d    = flags_q;
        acc_d      = acc_q;

        if (w_accept) begin
            s1_valid_d = 1'b1;
            s1_d.op    = alu_op_e'(op_i);
            s1_d.a     = a_i;
            s1_d.b     = b_i;
            s1_d.use_acc = use_acc_i;
            s1_d.wr_acc  = wr_acc_i;
        end else if (w_s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (w_s1_adv) begin
            s2_valid_d = 1'b1;
            res_d      = w_alu_res;
            flags_d    = w_alu_flags;
        end else if (out_ready_i && s2_valid_q) begin
            s2_valid_d = 1'b0;
        end

        // Clear wins over a same-edge write; the advancing op has already
        // read the pre-clear value through w_alu_a.
        if (acc_clr_i) begin
            acc_d = ACC_INIT;
        end else if (w_s1_adv && s1_q.wr_acc) begin
            acc_d = w_alu_res;
        end
    end

    // State registers with synchronous reset dropping any in-flight op
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q       <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            res_q      <= 8'h00;
            flags_q    <= 4'h0;
            acc_q      <= ACC_INIT;
        end else begin
            s1_q       <= s1_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            res_q      <= res_d;
            flags_q    <= flags_d;
            acc_q      <= acc_d;
        end
    end

    // Registered outputs
    always_comb begin
        out_valid_o = s2_valid_q;
        res_o       = res_q;
        flags_o     = flags_q;
        acc_o       = acc_q;
    end

endmodule : alu_issue_stage
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_issue_stage
//  Purpose  : Directed self-checking bench for alu_issue_stage.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;

    localparam logic [7:0] C_ACC_INIT = 8'hA5;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       use_acc;
    logic       wr_acc;
    logic       acc_clr;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] res;
    logic [3:0] flags;
    logic [7:0] acc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.ACC_INIT(C_ACC_INIT)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .op_i        (op),
        .a_i         (a),
        .b_i         (b),
        .use_acc_i   (use_acc),
        .wr_acc_i    (wr_acc),
        .acc_clr_i   (acc_clr),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .res_o       (res),
        .flags_o     (flags),
        .acc_o       (acc)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] o, input logic [7:0] va, input logic [7:0] vb,
                         input logic ua, input logic wa);
        in_valid = 1'b1;
        op = o; a = va; b = vb; use_acc = ua; wr_acc = wa;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; acc_clr = 1'b0;
        op = 2'b00; a = 8'h00; b = 8'h00; use_acc = 1'b0; wr_acc = 1'b0;
        step(); step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (res !== 8'h00)      begin bad++; $display("FAIL reset_res got=%h exp=00", res); end
        total++; if (flags !== 4'h0)     begin bad++; $display("FAIL reset_flags got=%b exp=0000", flags); end
        total++; if (acc !== C_ACC_INIT) begin bad++; $display("FAIL reset_acc got=%h exp=%h", acc, C_ACC_INIT); end
        total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
        rst = 1'b0;
    endtask

    task automatic test_add();
        drive(2'b00, 8'h7F, 8'h01, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL add_latency got=%b exp=0", out_valid); end
        step();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b exp=1", out_valid); end
        total++; if (res !== 8'h80)      begin bad++; $display("FAIL add_res got=%h exp=80", res); end
        total++; if (flags !== 4'b1001)  begin bad++; $display("FAIL add_flags got=%b exp=1001", flags); end
        total++; if (acc !== C_ACC_INIT) begin bad++; $display("FAIL add_acc got=%h exp=%h", acc, C_ACC_INIT); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL add_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_logic_sub();
        drive(2'b01, 8'h05, 8'h05, 1'b0, 1'b0); step();
        drive(2'b10, 8'hF0, 8'h0F, 1'b0, 1'b0); step();
        total++; if (res !== 8'h00)     begin bad++; $display("FAIL sub_res got=%h exp=00", res); end
        total++; if (flags !== 4'b0110) begin bad++; $display("FAIL sub_flags got=%b exp=0110", flags); end
        drive(2'b01, 8'h00, 8'h01, 1'b0, 1'b0); step();
        total++; if (res !== 8'h00)     begin bad++; $display("FAIL and_res got=%h exp=00", res); end
        total++; if (flags !== 4'b0100) begin bad++; $display("FAIL and_flags got=%b exp=0100", flags); end
        drive(2'b11, 8'h80, 8'h01, 1'b0, 1'b0); step();
        total++; if (res !== 8'hFF)     begin bad++; $display("FAIL borrow_res got=%h exp=ff", res); end
        total++; if (flags !== 4'b1000) begin bad++; $display("FAIL borrow_flags got=%b exp=1000", flags); end
        in_valid = 1'b0; step();
        total++; if (res !== 8'h81)     begin bad++; $display("FAIL or_res got=%h exp=81", res); end
        total++; if (flags !== 4'b1000) begin bad++; $display("FAIL or_flags got=%b exp=1000", flags); end
        step();
    endtask

    task automatic test_back_to_back();
        // Bring the accumulator to zero: AND 0,0 written back
        drive(2'b10, 8'h00, 8'h00, 1'b0, 1'b1); step();
        in_valid = 1'b0; step();
        total++; if (acc !== 8'h00) begin bad++; $display("FAIL acc_zero got=%h exp=00", acc); end
        step();
        drive(2'b00, 8'h00, 8'h10, 1'b1, 1'b1);
        step();
        step();
        total++; if (out_valid !== 1'b1 || res !== 8'h10) begin bad++; $display("FAIL b2b_0 got=%b/%h exp=1/10", out_valid, res); end
        step();
        total++; if (out_valid !== 1'b1 || res !== 8'h20) begin bad++; $display("FAIL b2b_1 got=%b/%h exp=1/20", out_valid, res); end
        in_valid = 1'b0;
        step();
        total++; if (out_valid !== 1'b1 || res !== 8'h30) begin bad++; $display("FAIL b2b_2 got=%b/%h exp=1/30", out_valid, res); end
        total++; if (acc !== 8'h30) begin bad++; $display("FAIL b2b_acc got=%h exp=30", acc); end
        drive(2'b00, 8'h00, 8'hE0, 1'b1, 1'b1); step();
        in_valid = 1'b0; step();
        total++; if (res !== 8'h10)     begin bad++; $display("FAIL wrap_res got=%h exp=10", res); end
        total++; if (flags !== 4'b0010) begin bad++; $display("FAIL wrap_flags got=%b exp=0010", flags); end
        total++; if (acc !== 8'h10)     begin bad++; $display("FAIL wrap_acc got=%h exp=10", acc); end
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(2'b00, 8'h01, 8'h00, 1'b0, 1'b0);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready0 got=%b exp=1", in_ready); end
        step();
        a = 8'h02;
        step();
        a = 8'h03;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full got=%b exp=0", in_ready); end
        total++; if (out_valid !== 1'b1 || res !== 8'h01) begin bad++; $display("FAIL bp_hold0 got=%b/%h exp=1/01", out_valid, res); end
        step(); step();
        total++; if (res !== 8'h01 || in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold1 got=%h/%b exp=01/0", res, in_ready); end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b exp=1", in_ready); end
        step();
        a = 8'h04;
        total++; if (res !== 8'h02) begin bad++; $display("FAIL bp_drain2 got=%h exp=02", res); end
        step();
        in_valid = 1'b0;
        total++; if (res !== 8'h03) begin bad++; $display("FAIL bp_drain3 got=%h exp=03", res); end
        step();
        total++; if (out_valid !== 1'b1 || res !== 8'h04) begin bad++; $display("FAIL bp_drain4 got=%b/%h exp=1/04", out_valid, res); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_clear();
        // acc is 0x10 here; the op reads it at the same edge the clear lands
        drive(2'b00, 8'h00, 8'h01, 1'b1, 1'b1); step();
        in_valid = 1'b0; acc_clr = 1'b1; step();
        acc_clr = 1'b0;
        total++; if (acc !== C_ACC_INIT) begin bad++; $display("FAIL clr_acc got=%h exp=%h", acc, C_ACC_INIT); end
        total++; if (res !== 8'h11)      begin bad++; $display("FAIL clr_res got=%h exp=11", res); end
        step();
    endtask

    task automatic test_reset_full();
        out_ready = 1'b0;
        drive(2'b00, 8'h40, 8'h40, 1'b0, 1'b1); step();
        step();
        in_valid = 1'b0;
        total++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin bad++; $display("FAIL rf_full got=%b/%b exp=0/1", in_ready, out_valid); end
        rst = 1'b1; step(); rst = 1'b0;
        total++; if (out_valid !== 1'b0 || res !== 8'h00 || flags !== 4'h0) begin bad++; $display("FAIL rf_out got=%b/%h/%b exp=0/00/0000", out_valid, res, flags); end
        total++; if (acc !== C_ACC_INIT || in_ready !== 1'b1) begin bad++; $display("FAIL rf_state got=%h/%b exp=%h/1", acc, in_ready, C_ACC_INIT); end
        out_ready = 1'b1;
        step(); step();
        total++; if (out_valid !== 1'b0 || acc !== C_ACC_INIT) begin bad++; $display("FAIL rf_stale got=%b/%h exp=0/%h", out_valid, acc, C_ACC_INIT); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_logic_sub();
        test_back_to_back();
        test_backpressure();
        test_clear();
        test_reset_full();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_alu_issue_stage
`default_nettype wire

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Two-stage pipelined issue/writeback wrapper around the team's existing 8-bit combinational tiny_alu, with an 8-bit accumulator.
- Accepts ALU operations over a valid/ready handshake.
- Optionally substitutes the accumulator for operand A.
- Registers result and NZCO flags and presents them downstream over a second valid/ready handshake.
- Sits between the instruction/operand source and the register-file/writeback logic.

Parameters:
ACC_INIT, 8'h00, accumulator value after reset and after acc_clr_i.

Ports:
clk_i  input  1  clock; all state on rising edge
rst_i  input  1  reset; synchronous, active-high
in_valid_i  input  1  operation request valid
in_ready_o  output  1  stage 1 can accept this cycle
op_i  input  2  00 ADD, 01 SUB, 10 AND, 11 OR
a_i  input  8  operand A (ignored when use_acc_i=1)
b_i  input  8  operand B
use_acc_i  input  1  operand A := accumulator, sampled at ALU evaluation
wr_acc_i  input  1  result is written into accumulator
acc_clr_i  input  1  synchronous accumulator clear to ACC_INIT
out_valid_o  output  1  result/flags valid
out_ready_i  input  1  downstream accepts
res_o  output  8  registered result
flags_o  output  4  registered {N,Z,C,O}
acc_o  output  8  current accumulator value

Behaviour:
- Reset (rst_i=1 at edge) has priority over everything:
  - s1_valid=0, s2_valid=0, out_valid_o=0.
  - res_o=8'h00, flags_o=4'h0, acc=ACC_INIT.
  - Any in-flight operation is dropped.
  - in_ready_o=1 in the first cycle after reset.
- Stage 1 (operand register):
  - Captures op, a, b, use_acc and wr_acc when in_valid_i && in_ready_o.
- Stage 2 (result register):
  - s1_adv = s1_valid && (!s2_valid || out_ready_i).
  - On s1_adv:
    - ALU evaluated combinationally from stage 1: A = use_acc ? acc : a.
    - res_o/flags_o loaded; s2_valid=1.
  - If out_ready_i && s2_valid && !s1_adv: s2_valid=0.
  - res_o/flags_o hold their value while s2_valid && !out_ready_i; they are not cleared on drain.
- in_ready_o = !s1_valid || s1_adv.
  - Combinational from out_ready_i; no combinational path from in_valid_i.
- Latency: accept at edge k, out_valid_o high after edge k+1.
- Throughput: 1 op/cycle with out_ready_i held high.
- Full condition: both stages valid and out_ready_i=0, giving in_ready_o=0. At most 2 ops are held.
- Accumulator:
  - On s1_adv with stage-1 wr_acc=1: acc := ALU result at the same edge.
  - An op already waiting in stage 1 therefore sees the updated acc. Back-to-back dependent accumulations need no stall or forwarding.
  - acc_clr_i and a write at the same edge: clear wins (acc=ACC_INIT).
  - A clear at the same edge a use_acc op advances: the op uses the pre-clear value.
- Flags are taken unmodified from tiny_alu:
  - C and O are 0 for AND/OR.
  - C for SUB is carry-out of A + ~B + 1 (1 = no borrow).
- Wrap-around: 8-bit modular arithmetic; the accumulator wraps silently, with the carry reported in flags.
- Out-of-handshake inputs are don't-care. Outputs are stable while out_valid_o && !out_ready_i.

Decomposition:
- Shared package alu_pkg:
  - alu_op_e enum (ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_OR=2'b11).
  - Flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_O=0.
  - Stage-1 packed struct (op, a, b, use_acc, wr_acc).
- One sub-module: tiny_alu, instantiated unmodified between the stages. No other hierarchy.

Test Plan:
- ADD 0x7F+0x01, out_ready_i=1 -> two cycles later res_o=0x80, flags_o=4'b1001, acc unchanged.
- SUB 0x05-0x05 -> res_o=0x00, flags_o=4'b0110. Then AND 0xF0&0x0F -> res_o=0x00, flags_o=4'b0100.
- Three back-to-back ADD b=0x10 with use_acc=1, wr_acc=1 from acc=0x00 -> consecutive outputs 0x10, 0x20, 0x30, no bubbles. Then ADD b=0xE0 -> res 0x10, C=1, acc_o=0x10.
- Backpressure: out_ready_i=0 while issuing 4 ops -> in_ready_o falls after 2 accepts. res_o stays stable. Releasing out_ready_i drains all 4 in order with no loss or duplication.
- acc_clr_i asserted on the same edge as a wr_acc advance -> acc_o=ACC_INIT next cycle, and the op's res_o still reflects the pre-clear acc.
- rst_i asserted with both stages full -> next cycle out_valid_o=0, res_o=0, flags_o=0, acc_o=ACC_INIT, in_ready_o=1. No stale output appears afterwards.
